// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit single-cycle CPU.
// Opcodes, ALU op encodings and datapath widths.
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int REG_IDX_W = 2;

  localparam int DST_HI = 3;
  localparam int DST_LO = 2;
  localparam int SRC_HI = 1;
  localparam int SRC_LO = 0;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [7:0] OP_HLT   = 8'hFF;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/exec_dmem.sv
// Byte-wide data memory: async read, sync write, sync clear.
// Clear takes priority over a pending write.
module exec_dmem
  import cpu_pkg::*;
#(
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/exec_datapath.sv
// Execute/memory slice: decoder, add/sub ALU and data memory.
// Everything but the memory write is combinational.
module exec_datapath
  import cpu_pkg::*;
#(
  parameter int DMEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           instr,
  input  logic [DATA_W-1:0]    next_byte,
  input  logic [DATA_W-1:0]    rd_data1,
  input  logic [DATA_W-1:0]    rd_data2,
  output logic [REG_IDX_W-1:0] reg_dst,
  output logic [REG_IDX_W-1:0] reg_src,
  output logic                 reg_write,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 is_two_byte,
  output logic                 halt,
  output logic [DATA_W-1:0]    alu_result
);

  logic [3:0]        op;
  logic              alu_op;
  logic              use_imm;
  logic              is_load;
  logic              is_store;
  logic              wr_en;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] mem_rdata;

  assign op      = instr[7:4];
  assign reg_dst = instr[DST_HI:DST_LO];
  assign reg_src = instr[SRC_HI:SRC_LO];

  always_comb begin
    alu_op      = ALU_ADD;
    use_imm     = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    wr_en       = 1'b0;
    is_two_byte = 1'b0;
    halt        = 1'b0;
    unique case (1'b1)
      (instr == OP_HLT): halt = 1'b1;
      (op == OP_ADD): wr_en = 1'b1;
      (op == OP_SUB): begin
        wr_en  = 1'b1;
        alu_op = ALU_SUB;
      end
      (op == OP_ADDI): begin
        wr_en       = 1'b1;
        use_imm     = 1'b1;
        is_two_byte = 1'b1;
      end
      (op == OP_SUBI): begin
        wr_en       = 1'b1;
        use_imm     = 1'b1;
        alu_op      = ALU_SUB;
        is_two_byte = 1'b1;
      end
      (op == OP_LOAD): begin
        wr_en       = 1'b1;
        is_load     = 1'b1;
        is_two_byte = 1'b1;
      end
      (op == OP_STORE): begin
        is_store    = 1'b1;
        is_two_byte = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_b      = use_imm ? next_byte : rd_data2;
  assign alu_result = (alu_op == ALU_SUB) ? rd_data1 - alu_b
                                          : rd_data1 + alu_b;

  assign wb_data   = is_load ? mem_rdata : alu_result;
  // Write-back is suppressed while reset is held.
  assign reg_write = wr_en & rst;

  exec_dmem #(
    .DMEM_DEPTH(DMEM_DEPTH)
  ) u_dmem (
    .clk  (clk),
    .rst  (rst),
    .we   (is_store),
    .addr (next_byte),
    .wdata(rd_data2),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_exec_datapath.sv
// Self-checking bench for exec_datapath: vector table,
// hand-written store/load/reset sequences and random ops.
module tb_exec_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic [7:0] next_byte;
  logic [7:0] rd_data1;
  logic [7:0] rd_data2;
  logic [1:0] reg_dst;
  logic [1:0] reg_src;
  logic       reg_write;
  logic [7:0] wb_data;
  logic       is_two_byte;
  logic       halt;
  logic [7:0] alu_result;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [256];

  always #5 clk = ~clk;

  exec_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .next_byte  (next_byte),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .reg_dst    (reg_dst),
    .reg_src    (reg_src),
    .reg_write  (reg_write),
    .wb_data    (wb_data),
    .is_two_byte(is_two_byte),
    .halt       (halt),
    .alu_result (alu_result)
  );

  typedef struct {
    logic [7:0] instr;
    logic [7:0] nb;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] wb;
    logic       chk_wb;
    logic       rw;
    logic       two;
    logic       hl;
    logic [1:0] dst;
    logic [1:0] src;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: instruction semantics from the opcode table.
  task automatic model(output logic [7:0] wb, output logic rw,
                       output logic two, output logic hl,
                       output logic wb_valid);
    int op;
    op = int'(instr[7:4]);
    wb = 8'h00; rw = 0; two = 0; wb_valid = 0;
    hl = (instr == 8'hFF);
    case (op)
      0: begin wb = 8'((rd_data1 + rd_data2) % 256); rw = 1; end
      1: begin wb = 8'((256 + rd_data1 - rd_data2) % 256); rw = 1; end
      2: begin wb = 8'((rd_data1 + next_byte) % 256); rw = 1; two = 1; end
      3: begin wb = 8'((256 + rd_data1 - next_byte) % 256); rw = 1; two = 1; end
      4: begin wb = ref_mem[next_byte]; rw = 1; two = 1; end
      5: two = 1;
      default: ;
    endcase
    wb_valid = rw;
    if (!rst) rw = 0;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e_wb;
    logic e_rw, e_two, e_hl, e_v;
    model(e_wb, e_rw, e_two, e_hl, e_v);
    chk({tag, ".reg_write"}, 8'(reg_write), 8'(e_rw));
    chk({tag, ".two_byte"}, 8'(is_two_byte), 8'(e_two));
    chk({tag, ".halt"}, 8'(halt), 8'(e_hl));
    chk({tag, ".reg_dst"}, 8'(reg_dst), 8'(instr[3:2]));
    chk({tag, ".reg_src"}, 8'(reg_src), 8'(instr[1:0]));
    if (e_v) chk({tag, ".wb_data"}, wb_data, e_wb);
  endtask

  // Clock edge with model memory update from the held inputs.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    end else if (instr[7:4] == 4'h5) begin
      ref_mem[next_byte] = rd_data2;
    end
    #1;
  endtask

  task automatic drive(input logic [7:0] i, input logic [7:0] nb,
                       input logic [7:0] d1, input logic [7:0] d2);
    instr = i; next_byte = nb; rd_data1 = d1; rd_data2 = d2;
    #1;
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'h00, 8'h05, 8'h03, 8'h08, 1, 1, 0, 0, 2'd0, 2'd1};
    vecs[1] = '{8'h16, 8'h00, 8'h02, 8'h05, 8'hFD, 1, 1, 0, 0, 2'd1, 2'd2};
    vecs[2] = '{8'h2C, 8'h10, 8'hF8, 8'h00, 8'h08, 1, 1, 1, 0, 2'd3, 2'd0};
    vecs[3] = '{8'h3B, 8'h07, 8'h03, 8'h99, 8'hFC, 1, 1, 1, 0, 2'd2, 2'd3};
    vecs[4] = '{8'hFF, 8'h12, 8'h11, 8'h22, 8'h00, 0, 0, 0, 1, 2'd3, 2'd3};
    vecs[5] = '{8'hF0, 8'h12, 8'h11, 8'h22, 8'h00, 0, 0, 0, 0, 2'd0, 2'd0};
    vecs[6] = '{8'hFE, 8'h12, 8'h11, 8'h22, 8'h00, 0, 0, 0, 0, 2'd3, 2'd2};
    vecs[7] = '{8'h6A, 8'h34, 8'h11, 8'h22, 8'h00, 0, 0, 0, 0, 2'd2, 2'd2};

    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;

    // Reset: reg_write low while rst held.
    rst = 1'b0;
    drive(8'h01, 8'h00, 8'h05, 8'h03);
    chk("rst.reg_write", 8'(reg_write), 8'h00);
    tick();
    rst = 1'b1;
    for (int a = 0; a < 256; a += 51) begin
      drive(8'h40, 8'(a), 8'h00, 8'h00);
      chk("rst.mem_zero", wb_data, 8'h00);
    end

    // Vector table.
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].instr, vecs[v].nb, vecs[v].d1, vecs[v].d2);
      chk($sformatf("vec%0d.reg_write", v), 8'(reg_write), 8'(vecs[v].rw));
      chk($sformatf("vec%0d.two_byte", v), 8'(is_two_byte), 8'(vecs[v].two));
      chk($sformatf("vec%0d.halt", v), 8'(halt), 8'(vecs[v].hl));
      chk($sformatf("vec%0d.reg_dst", v), 8'(reg_dst), 8'(vecs[v].dst));
      chk($sformatf("vec%0d.reg_src", v), 8'(reg_src), 8'(vecs[v].src));
      if (vecs[v].chk_wb)
        chk($sformatf("vec%0d.wb_data", v), wb_data, vecs[v].wb);
      tick();
    end

    // STORE then LOAD.
    drive(8'h53, 8'h80, 8'h00, 8'hAB);
    chk("st.reg_write", 8'(reg_write), 8'h00);
    chk("st.two_byte", 8'(is_two_byte), 8'h01);
    tick();
    drive(8'h44, 8'h80, 8'h00, 8'h00);
    chk("ld.wb_data", wb_data, 8'hAB);
    chk("ld.reg_write", 8'(reg_write), 8'h01);
    chk("ld.reg_dst", 8'(reg_dst), 8'h01);
    tick();

    // HLT leaves memory untouched.
    drive(8'hFF, 8'h80, 8'h00, 8'h5A);
    tick();
    drive(8'h40, 8'h80, 8'h00, 8'h00);
    chk("hlt.mem", wb_data, 8'hAB);

    // Store during reset is dropped and memory cleared.
    drive(8'h50, 8'h20, 8'h00, 8'h55);
    tick();
    drive(8'h40, 8'h20, 8'h00, 8'h00);
    chk("pre_rst.ld", wb_data, 8'h55);
    rst = 1'b0;
    drive(8'h50, 8'h20, 8'h00, 8'h77);
    chk("in_rst.reg_write", 8'(reg_write), 8'h00);
    tick();
    rst = 1'b1;
    drive(8'h40, 8'h20, 8'h00, 8'h00);
    chk("post_rst.ld20", wb_data, 8'h00);
    drive(8'h40, 8'h80, 8'h00, 8'h00);
    chk("post_rst.ld80", wb_data, 8'h00);

    // Randomized against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] ri;
      int sel;
      sel = $urandom_range(0, 9);
      ri = 8'($urandom);
      if (sel < 7) ri[7:4] = 4'(sel % 6);
      else if (sel == 7) ri = 8'hFF;
      rst = ($urandom_range(0, 39) != 0);
      // Small address window so loads hit stored bytes.
      drive(ri, 8'($urandom_range(0, 15)) | (8'($urandom_range(0, 1)) << 7),
            8'($urandom), 8'($urandom));
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
